// File: rtl/defines.sv
// Shared Decode/Execute definitions: datapath widths, control-word encodings and
// the ID/EX bundle that is registered as a single unit at the stage boundary.
package defines;

   localparam int DATA_WIDTH     = 32;
   localparam int REG_ADDR_WIDTH = 5;

   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_U = 3'd3,
      IMM_J = 3'd4
   } imm_sel_e;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9,
      ALU_LUI  = 4'd10
   } alu_op_e;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2
   } wb_sel_e;

   typedef struct packed {
      alu_op_e alu_op;
      logic    alu_src;
      logic    mem_read;
      logic    mem_write;
      logic    reg_write;
      wb_sel_e wb_sel;
   } id_ex_ctrl_t;

   localparam id_ex_ctrl_t CTRL_NOP = '{
      alu_op:    ALU_ADD,
      alu_src:   1'b0,
      mem_read:  1'b0,
      mem_write: 1'b0,
      reg_write: 1'b0,
      wb_sel:    WB_ALU
   };

   typedef struct packed {
      logic [DATA_WIDTH-1:0]     pc;
      logic [DATA_WIDTH-1:0]     rs1_data;
      logic [DATA_WIDTH-1:0]     rs2_data;
      logic [DATA_WIDTH-1:0]     imm;
      logic [REG_ADDR_WIDTH-1:0] rs1_addr;
      logic [REG_ADDR_WIDTH-1:0] rs2_addr;
      logic [REG_ADDR_WIDTH-1:0] rd_addr;
      id_ex_ctrl_t               ctrl;
   } id_ex_bundle_t;

   localparam id_ex_bundle_t BUNDLE_RESET = '{
      pc:       {DATA_WIDTH{1'b0}},
      rs1_data: {DATA_WIDTH{1'b0}},
      rs2_data: {DATA_WIDTH{1'b0}},
      imm:      {DATA_WIDTH{1'b0}},
      rs1_addr: {REG_ADDR_WIDTH{1'b0}},
      rs2_addr: {REG_ADDR_WIDTH{1'b0}},
      rd_addr:  {REG_ADDR_WIDTH{1'b0}},
      ctrl:     CTRL_NOP
   };

   // A killed bundle keeps its (harmless) data but can no longer write anything.
   function automatic id_ex_bundle_t kill_bundle(input id_ex_bundle_t b);
      id_ex_bundle_t k;
      k      = b;
      k.ctrl = CTRL_NOP;
      return k;
   endfunction

endpackage

// File: rtl/id_ex_skid_reg_chk.sv
// Invariant checks for the ID/EX skid register: legal occupancy states, ready
// tracking the skid entry, and the control word neutralised after reset/flush.
module id_ex_skid_reg_chk #(
   parameter int CTRL_WIDTH = $bits(defines::id_ex_ctrl_t)
) (
   input logic                  clk_i,
   input logic                  rst_i,
   input logic                  flush_i,
   input logic                  m_valid_i,
   input logic                  s_valid_i,
   input logic                  ready_i,
   input logic [CTRL_WIDTH-1:0] ctrl_i
);
   import defines::*;

   a_no_skid_without_main : assert property (@(posedge clk_i) disable iff (rst_i)
      !(!m_valid_i && s_valid_i));

   a_ready_tracks_skid : assert property (@(posedge clk_i) disable iff (rst_i)
      (ready_i == !s_valid_i));

   a_ctrl_nop_after_kill : assert property (@(posedge clk_i)
      (rst_i || flush_i) |=> (ctrl_i == CTRL_WIDTH'(CTRL_NOP)));

endmodule

// File: rtl/id_ex_skid_reg.sv
// Decode->Execute pipeline register with a 2-entry skid buffer: ready_o is a
// flop, so Decode never sees a combinational path from Execute's ready_i.
module id_ex_skid_reg #(
   parameter int DATA_WIDTH     = defines::DATA_WIDTH,
   parameter int REG_ADDR_WIDTH = defines::REG_ADDR_WIDTH,
   parameter int CTRL_WIDTH     = $bits(defines::id_ex_ctrl_t)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      flush_i,
   input  logic                      valid_i,
   output logic                      ready_o,
   input  logic [DATA_WIDTH-1:0]     pc_i,
   input  logic [DATA_WIDTH-1:0]     rs1_data_i,
   input  logic [DATA_WIDTH-1:0]     rs2_data_i,
   input  logic [DATA_WIDTH-1:0]     imm_i,
   input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
   input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
   input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
   input  defines::id_ex_ctrl_t      ctrl_i,
   output logic                      valid_o,
   input  logic                      ready_i,
   output logic [DATA_WIDTH-1:0]     pc_o,
   output logic [DATA_WIDTH-1:0]     rs1_data_o,
   output logic [DATA_WIDTH-1:0]     rs2_data_o,
   output logic [DATA_WIDTH-1:0]     imm_o,
   output logic [REG_ADDR_WIDTH-1:0] rs1_addr_o,
   output logic [REG_ADDR_WIDTH-1:0] rs2_addr_o,
   output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
   output defines::id_ex_ctrl_t      ctrl_o
);
   import defines::*;

   id_ex_bundle_t m_r;
   id_ex_bundle_t s_r;
   id_ex_bundle_t in_s;
   logic          m_valid_r;
   logic          s_valid_r;
   logic          ready_r;
   logic          accept_s;
   logic          emit_s;

   // Gather the decode-side fields into one bundle.
   always_comb begin
      in_s = '{
         pc:       pc_i,
         rs1_data: rs1_data_i,
         rs2_data: rs2_data_i,
         imm:      imm_i,
         rs1_addr: rs1_addr_i,
         rs2_addr: rs2_addr_i,
         rd_addr:  rd_addr_i,
         ctrl:     ctrl_i
      };
   end

   assign accept_s = valid_i & ready_r;
   assign emit_s   = m_valid_r & ready_i;

   // Occupancy control and main/skid bundle storage.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         m_valid_r <= 1'b0;
         s_valid_r <= 1'b0;
         ready_r   <= 1'b1;
         m_r       <= BUNDLE_RESET;
         s_r       <= BUNDLE_RESET;
      end else if (flush_i) begin
         m_valid_r <= 1'b0;
         s_valid_r <= 1'b0;
         ready_r   <= 1'b1;
         m_r       <= kill_bundle(m_r);
      end else begin
         case ({m_valid_r, s_valid_r})
            2'b00: begin
               if (accept_s) begin
                  m_r       <= in_s;
                  m_valid_r <= 1'b1;
               end
            end
            2'b10: begin
               if (accept_s && emit_s) begin
                  m_r <= in_s;
               end else if (emit_s) begin
                  m_valid_r <= 1'b0;
               end else if (accept_s) begin
                  s_r       <= in_s;
                  s_valid_r <= 1'b1;
                  ready_r   <= 1'b0;
               end
            end
            2'b11: begin
               if (emit_s) begin
                  m_r       <= s_r;
                  s_valid_r <= 1'b0;
                  ready_r   <= 1'b1;
               end
            end
            default: begin
               // Illegal skid-only state: promote the skid so nothing is lost.
               m_r       <= s_r;
               m_valid_r <= 1'b1;
               s_valid_r <= 1'b0;
               ready_r   <= 1'b1;
            end
         endcase
      end
   end

   assign ready_o    = ready_r;
   assign valid_o    = m_valid_r;
   assign pc_o       = m_r.pc;
   assign rs1_data_o = m_r.rs1_data;
   assign rs2_data_o = m_r.rs2_data;
   assign imm_o      = m_r.imm;
   assign rs1_addr_o = m_r.rs1_addr;
   assign rs2_addr_o = m_r.rs2_addr;
   assign rd_addr_o  = m_r.rd_addr;
   assign ctrl_o     = m_r.ctrl;

   id_ex_skid_reg_chk #(
      .CTRL_WIDTH (CTRL_WIDTH)
   ) u_chk (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .flush_i   (flush_i),
      .m_valid_i (m_valid_r),
      .s_valid_i (s_valid_r),
      .ready_i   (ready_r),
      .ctrl_i    (m_r.ctrl)
   );

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Scoreboard bench for id_ex_skid_reg: the reference is a FIFO of accepted
// bundles with capacity two; a negedge monitor checks handshakes and pops on transfer.
module tb_id_ex_skid_reg;
   import defines::*;

   logic                      clk_i = 1'b0;
   logic                      rst_i, flush_i, valid_i, ready_i;
   logic                      ready_o, valid_o;
   logic [DATA_WIDTH-1:0]     pc_i, rs1_data_i, rs2_data_i, imm_i;
   logic [REG_ADDR_WIDTH-1:0] rs1_addr_i, rs2_addr_i, rd_addr_i;
   id_ex_ctrl_t               ctrl_i, ctrl_o;
   logic [DATA_WIDTH-1:0]     pc_o, rs1_data_o, rs2_data_o, imm_o;
   logic [REG_ADDR_WIDTH-1:0] rs1_addr_o, rs2_addr_o, rd_addr_o;

   id_ex_bundle_t cur_b;
   id_ex_bundle_t out_b;
   id_ex_bundle_t exp_q[$];
   int            n_tests = 0;
   int            n_fail  = 0;
   bit            mon_en      = 1'b0;
   bit            sb_ready    = 1'b1;
   bit            expect_nop  = 1'b0;
   bit            expect_zero = 1'b0;
   bit            rdy_tab [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

   always #5 clk_i = ~clk_i;

   id_ex_skid_reg dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .flush_i    (flush_i),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .pc_i       (pc_i),
      .rs1_data_i (rs1_data_i),
      .rs2_data_i (rs2_data_i),
      .imm_i      (imm_i),
      .rs1_addr_i (rs1_addr_i),
      .rs2_addr_i (rs2_addr_i),
      .rd_addr_i  (rd_addr_i),
      .ctrl_i     (ctrl_i),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .pc_o       (pc_o),
      .rs1_data_o (rs1_data_o),
      .rs2_data_o (rs2_data_o),
      .imm_o      (imm_o),
      .rs1_addr_o (rs1_addr_o),
      .rs2_addr_o (rs2_addr_o),
      .rd_addr_o  (rd_addr_o),
      .ctrl_o     (ctrl_o)
   );

   assign pc_i       = cur_b.pc;
   assign rs1_data_i = cur_b.rs1_data;
   assign rs2_data_i = cur_b.rs2_data;
   assign imm_i      = cur_b.imm;
   assign rs1_addr_i = cur_b.rs1_addr;
   assign rs2_addr_i = cur_b.rs2_addr;
   assign rd_addr_i  = cur_b.rd_addr;
   assign ctrl_i     = cur_b.ctrl;

   assign out_b = '{pc: pc_o, rs1_data: rs1_data_o, rs2_data: rs2_data_o, imm: imm_o,
                    rs1_addr: rs1_addr_o, rs2_addr: rs2_addr_o, rd_addr: rd_addr_o,
                    ctrl: ctrl_o};

   function automatic void chk(input string name, input logic [159:0] act,
                               input logic [159:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic id_ex_bundle_t rand_bundle(input logic [31:0] pc, input logic [31:0] imm);
      id_ex_bundle_t b;
      b.pc             = pc;
      b.rs1_data       = $urandom();
      b.rs2_data       = $urandom();
      b.imm            = imm;
      b.rs1_addr       = 5'($urandom_range(0, 31));
      b.rs2_addr       = 5'($urandom_range(0, 31));
      b.rd_addr        = 5'($urandom_range(0, 31));
      b.ctrl.alu_op    = alu_op_e'(4'($urandom_range(0, 10)));
      b.ctrl.alu_src   = 1'($urandom_range(0, 1));
      b.ctrl.mem_read  = 1'($urandom_range(0, 1));
      b.ctrl.mem_write = 1'($urandom_range(0, 1));
      b.ctrl.reg_write = 1'b1;
      b.ctrl.wb_sel    = wb_sel_e'(2'($urandom_range(0, 2)));
      return b;
   endfunction

   // One clock of stimulus; afterwards the reference FIFO absorbs what the edge did.
   task automatic cycle(input bit v, input bit r, input bit f, input bit rs,
                        input id_ex_bundle_t b, output bit acc);
      valid_i = v;
      ready_i = r;
      flush_i = f;
      rst_i   = rs;
      cur_b   = b;
      @(posedge clk_i);
      #1;
      acc = 1'b0;
      if (rs) begin
         exp_q.delete();
         expect_nop  = 1'b1;
         expect_zero = 1'b1;
      end else if (f) begin
         exp_q.delete();
         expect_nop = 1'b1;
      end else if (v && sb_ready) begin
         exp_q.push_back(b);
         acc         = 1'b1;
         expect_nop  = 1'b0;
         expect_zero = 1'b0;
      end
      mon_en = 1'b1;
   endtask

   task automatic drain(input int n);
      bit acc;
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, rand_bundle(32'h0, 32'h0), acc);
   endtask

   // Monitor: presented handshakes follow FIFO occupancy; each transfer pops in order.
   always @(negedge clk_i) begin : monitor
      int            occ;
      id_ex_bundle_t exp_b;
      if (mon_en) begin
         occ      = exp_q.size();
         sb_ready = (occ < 2);
         chk("valid_o", 160'(valid_o), 160'(occ > 0));
         chk("ready_o", 160'(ready_o), 160'(occ < 2));
         if (!rst_i && valid_o && ready_i && occ > 0) begin
            exp_b = exp_q.pop_front();
            chk("bundle", 160'(out_b), 160'(exp_b));
         end
         if (expect_nop && !valid_o) chk("ctrl_nop", 160'(ctrl_o), 160'(CTRL_NOP));
         if (expect_zero) chk("reset_data", 160'(out_b), 160'(BUNDLE_RESET));
      end
   end

   initial begin : stimulus
      bit            acc;
      bit            v, r, f, r0;
      logic [31:0]   pc_next;
      id_ex_bundle_t b;

      // Reset held two cycles with valid_i high.
      cycle(1'b1, 1'b1, 1'b0, 1'b1, rand_bundle(32'h4, 32'h5), acc);
      cycle(1'b1, 1'b1, 1'b0, 1'b1, rand_bundle(32'h8, 32'h9), acc);
      chk("rst_imm", 160'(imm_o), 160'(32'h0));

      // Streaming at full rate.
      for (int k = 0; k < 8; k++)
         cycle(1'b1, 1'b1, 1'b0, 1'b0, rand_bundle(32'(4 * k), 32'hFFFF_F800 + 32'(k)), acc);
      drain(2);

      // Back-pressure: Decode holds its bundle until it is taken.
      pc_next = 32'h0;
      b = rand_bundle(pc_next, 32'h100);
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, rdy_tab[i], 1'b0, 1'b0, b, acc);
         if (acc) begin
            pc_next = pc_next + 32'h4;
            b = rand_bundle(pc_next, 32'h100 + pc_next);
         end
         if (i == 3) begin
            chk("bp_ready_low", 160'(ready_o), 160'(1'b0));
            chk("bp_main_pc", 160'(pc_o), 160'(32'h8));
         end
      end
      drain(3);

      // Flush while full, with a live bundle on the input.
      cycle(1'b1, 1'b0, 1'b0, 1'b0, rand_bundle(32'h20, 32'h1), acc);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, rand_bundle(32'h24, 32'h2), acc);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, rand_bundle(32'h40, 32'h3), acc);
      chk("flush_valid", 160'(valid_o), 160'(1'b0));
      chk("flush_ready", 160'(ready_o), 160'(1'b1));
      chk("flush_regwr", 160'(ctrl_o.reg_write), 160'(1'b0));
      drain(3);

      // Reset pulse while full and stalled.
      cycle(1'b1, 1'b0, 1'b0, 1'b0, rand_bundle(32'h30, 32'h4), acc);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, rand_bundle(32'h34, 32'h5), acc);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, rand_bundle(32'h38, 32'h6), acc);
      chk("rst_stall_valid", 160'(valid_o), 160'(1'b0));
      drain(3);

      // Random traffic with sparse flushes.
      b = rand_bundle($urandom(), $urandom());
      for (int n = 0; n < 10000; n++) begin
         v = ($urandom_range(0, 99) < 70);
         r = ($urandom_range(0, 99) < 60);
         f = ($urandom_range(0, 99) < 2);
         cycle(v, r, f, 1'b0, b, acc);
         if (acc || f) b = rand_bundle($urandom(), $urandom());
         if (n % 32 == 0) begin
            r0      = ready_o;
            ready_i = ~ready_i;
            #1;
            chk("ready_comb", 160'(ready_o), 160'(r0));
            ready_i = ~ready_i;
         end
      end
      drain(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
